mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch, data) arbiter onto a single
// unified memory port with fixed backend latency. One transaction at a time
// walks IDLE -> ISSUE -> WAIT -> DONE.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie-breaking;
// without it the data port always wins simultaneous requests.
module mem_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ack,
    output logic [15:0] if_rdata,
    output logic        if_stall,
    input  logic        dm_re,
    input  logic        dm_we,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic        dm_ack,
    output logic [15:0] dm_rdata,
    output logic        dm_stall,
    output logic [15:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        dm_req;
    logic        pick_if;
    logic        grant;
    logic        gnt_if_q;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;

`ifdef MEM_ARB_RR_EN
    logic        last_dm;

    // Round-robin history: remembers whether the data port took the last grant
    always_ff @(posedge clk) begin
        if (reset) begin
            last_dm <= 1'b1;
        end else if (grant) begin
            last_dm <= ~pick_if;
        end
    end
`endif

    // Request decode and arbitration; a grant is only possible from IDLE
    always_comb begin
        dm_req = dm_re | dm_we;
`ifdef MEM_ARB_RR_EN
        pick_if = if_req & (~dm_req | last_dm);
`else
        pick_if = if_req & ~dm_req;
`endif
        grant = (state == IDLE) & (if_req | dm_req);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (if_req | dm_req) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (cnt == 4'd1) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: strobes only in ISSUE, ack only in DONE, stalls follow acks
    always_comb begin
        mem_re   = (state == ISSUE) & ~we_q;
        mem_we   = (state == ISSUE) & we_q;
        busy     = (state != IDLE);
        if_ack   = (state == DONE) & gnt_if_q;
        dm_ack   = (state == DONE) & ~gnt_if_q;
        if_stall = if_req & ~if_ack;
        dm_stall = dm_req & ~dm_ack;
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Transaction registers, latency counter and per-port read-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= 4'd0;
            gnt_if_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 16'd0;
            wdata_q  <= 16'd0;
            if_rdata <= 16'd0;
            dm_rdata <= 16'd0;
        end else begin
            if (grant) begin
                // Write takes precedence when dm_re and dm_we are both high
                gnt_if_q <= pick_if;
                we_q     <= ~pick_if & dm_we;
                addr_q   <= pick_if ? if_addr : dm_addr;
                wdata_q  <= dm_wdata;
            end
            case (state)
                ISSUE:   cnt <= 4'(LATENCY);
                WAIT:    cnt <= cnt - 4'd1;
                default: cnt <= cnt;
            endcase
            if ((state == WAIT) && (cnt == 4'd1) && !we_q) begin
                if (gnt_if_q) begin
                    if_rdata <= mem_rdata;
                end else begin
                    dm_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (LATENCY 2, 1, 15) share one stimulus
// stream. A transaction-level model predicts every output each cycle from the
// grant cycle and latency; directed literal expectations pin key timings.
module tb_mem_arbiter;

    localparam int N = 3;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    localparam int S_IF_ACK = 0, S_DM_ACK = 1, S_IF_RD = 2, S_DM_RD = 3, S_MEM_RE = 4,
                   S_MEM_WE = 5, S_MEM_ADDR = 6, S_MEM_WD = 7, S_IF_STALL = 8,
                   S_DM_STALL = 9, S_BUSY = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        dm_re, dm_we;
    logic [15:0] dm_addr, dm_wdata;
    logic [15:0] mem_rdata;

    logic        if_ack_a   [N];
    logic [15:0] if_rdata_a [N];
    logic        if_stall_a [N];
    logic        dm_ack_a   [N];
    logic [15:0] dm_rdata_a [N];
    logic        dm_stall_a [N];
    logic [15:0] mem_addr_a [N];
    logic        mem_re_a   [N];
    logic        mem_we_a   [N];
    logic [15:0] mem_wd_a   [N];
    logic        busy_a     [N];

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        mem_arbiter #(.LATENCY(lat_of(k))) u_dut (
            .clk       (clk),
            .reset     (rst),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_ack    (if_ack_a[k]),
            .if_rdata  (if_rdata_a[k]),
            .if_stall  (if_stall_a[k]),
            .dm_re     (dm_re),
            .dm_we     (dm_we),
            .dm_addr   (dm_addr),
            .dm_wdata  (dm_wdata),
            .dm_ack    (dm_ack_a[k]),
            .dm_rdata  (dm_rdata_a[k]),
            .dm_stall  (dm_stall_a[k]),
            .mem_addr  (mem_addr_a[k]),
            .mem_re    (mem_re_a[k]),
            .mem_we    (mem_we_a[k]),
            .mem_wdata (mem_wd_a[k]),
            .mem_rdata (mem_rdata),
            .busy      (busy_a[k])
        );
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          c;
        int          k;
        int          sig;
        logic [15:0] v;
        string       nm;
    } lit_t;
    lit_t lq[$];

    // Transaction-level model state per instance
    bit          m_act   [N];
    int          m_start [N];
    bit          m_isif  [N];
    bit          m_we    [N];
    logic [15:0] m_addr  [N];
    logic [15:0] m_wd    [N];
    logic [15:0] m_ifr   [N];
    logic [15:0] m_dmr   [N];
    bit          m_lastdm[N];
    bit          started = 1'b0;

    function automatic logic [15:0] sigval(input int id, input int k);
        case (id)
            S_IF_ACK:   return {15'd0, if_ack_a[k]};
            S_DM_ACK:   return {15'd0, dm_ack_a[k]};
            S_IF_RD:    return if_rdata_a[k];
            S_DM_RD:    return dm_rdata_a[k];
            S_MEM_RE:   return {15'd0, mem_re_a[k]};
            S_MEM_WE:   return {15'd0, mem_we_a[k]};
            S_MEM_ADDR: return mem_addr_a[k];
            S_MEM_WD:   return mem_wd_a[k];
            S_IF_STALL: return {15'd0, if_stall_a[k]};
            S_DM_STALL: return {15'd0, dm_stall_a[k]};
            default:    return {15'd0, busy_a[k]};
        endcase
    endfunction

    function automatic void chk(input string nm, input int k, input logic [15:0] act,
                                input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[L=%0d] cycle=%0d got=%h expected=%h", nm, lat_of(k), cyc, act, exp);
        end
    endfunction

    // Compare process: model expectations every cycle, literal pins when due, then advance model
    always @(negedge clk) begin : cmp
        int L;
        bit e_ifack, e_dmack, e_re, e_we, dreq, gif;
        if (started) begin
            for (int k = 0; k < N; k++) begin
                L       = lat_of(k);
                e_ifack = m_act[k] && (cyc == m_start[k] + L + 2) && m_isif[k];
                e_dmack = m_act[k] && (cyc == m_start[k] + L + 2) && !m_isif[k];
                e_re    = m_act[k] && (cyc == m_start[k] + 1) && !m_we[k];
                e_we    = m_act[k] && (cyc == m_start[k] + 1) && m_we[k];
                chk("if_ack",   k, sigval(S_IF_ACK, k),   {15'd0, e_ifack});
                chk("dm_ack",   k, sigval(S_DM_ACK, k),   {15'd0, e_dmack});
                chk("mem_re",   k, sigval(S_MEM_RE, k),   {15'd0, e_re});
                chk("mem_we",   k, sigval(S_MEM_WE, k),   {15'd0, e_we});
                chk("busy",     k, sigval(S_BUSY, k),     {15'd0, m_act[k]});
                chk("if_rdata", k, sigval(S_IF_RD, k),    m_ifr[k]);
                chk("dm_rdata", k, sigval(S_DM_RD, k),    m_dmr[k]);
                chk("mem_addr", k, sigval(S_MEM_ADDR, k), m_addr[k]);
                chk("if_stall", k, sigval(S_IF_STALL, k), {15'd0, if_req & ~e_ifack});
                chk("dm_stall", k, sigval(S_DM_STALL, k), {15'd0, (dm_re | dm_we) & ~e_dmack});
                if (e_we) chk("mem_wdata", k, sigval(S_MEM_WD, k), m_wd[k]);
            end
        end
        for (int i = lq.size() - 1; i >= 0; i--) begin
            if (lq[i].c == cyc) begin
                chk(lq[i].nm, lq[i].k, sigval(lq[i].sig, lq[i].k), lq[i].v);
                lq.delete(i);
            end
        end
        for (int k = 0; k < N; k++) begin
            L = lat_of(k);
            if (rst) begin
                m_act[k]    = 1'b0;
                m_addr[k]   = 16'd0;
                m_wd[k]     = 16'd0;
                m_ifr[k]    = 16'd0;
                m_dmr[k]    = 16'd0;
                m_lastdm[k] = 1'b1;
            end else if (m_act[k]) begin
                if ((cyc == m_start[k] + L + 1) && !m_we[k]) begin
                    if (m_isif[k]) m_ifr[k] = mem_rdata;
                    else           m_dmr[k] = mem_rdata;
                end
                if (cyc == m_start[k] + L + 2) m_act[k] = 1'b0;
            end else begin
                dreq = dm_re | dm_we;
                if (if_req | dreq) begin
`ifdef MEM_ARB_RR_EN
                    gif = if_req && (!dreq || m_lastdm[k]);
`else
                    gif = if_req && !dreq;
`endif
                    m_act[k]    = 1'b1;
                    m_start[k]  = cyc;
                    m_isif[k]   = gif;
                    m_we[k]     = !gif && dm_we;
                    m_addr[k]   = gif ? if_addr : dm_addr;
                    m_wd[k]     = dm_wdata;
                    m_lastdm[k] = !gif;
                end
            end
        end
        if (rst) started = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pin(input int c, input int k, input int sig, input logic [15:0] v,
                       input string nm);
        lit_t e;
        e.c = c; e.k = k; e.sig = sig; e.v = v; e.nm = nm;
        lq.push_back(e);
    endtask

    // Two simultaneous requests; the winner's request drops after its ack
    task automatic conflict(input bit first_if);
        int b;
        b = cyc;
        if_req = 1'b1; if_addr = 16'h0100; dm_re = 1'b1; dm_addr = 16'h0200;
        pin(b + 4, 0, first_if ? S_IF_ACK : S_DM_ACK, 16'd1, "lit_first_ack");
        pin(b + 4, 0, first_if ? S_DM_ACK : S_IF_ACK, 16'd0, "lit_loser_no_ack");
        pin(b + 4, 0, first_if ? S_IF_RD : S_DM_RD, 16'h1111, "lit_first_rdata");
        pin(b + 8, 0, first_if ? S_DM_STALL : S_IF_STALL, 16'd1, "lit_loser_stall");
        pin(b + 9, 0, first_if ? S_DM_ACK : S_IF_ACK, 16'd1, "lit_second_ack");
        pin(b + 9, 0, first_if ? S_DM_RD : S_IF_RD, 16'h2222, "lit_second_rdata");
        pin(b + 9, 0, first_if ? S_DM_STALL : S_IF_STALL, 16'd0, "lit_loser_stall_rel");
        wait_to(b + 3); mem_rdata = 16'h1111;
        wait_to(b + 4); mem_rdata = 16'hDEAD;
        wait_to(b + 5);
        if (first_if) if_req = 1'b0; else dm_re = 1'b0;
        wait_to(b + 8); mem_rdata = 16'h2222;
        wait_to(b + 9); mem_rdata = 16'hDEAD;
        wait_to(b + 10);
        if_req = 1'b0; dm_re = 1'b0;
    endtask

    initial begin
        int b;
        rst = 1'b1; if_req = 1'b0; if_addr = 16'd0;
        dm_re = 1'b0; dm_we = 1'b0; dm_addr = 16'd0; dm_wdata = 16'd0;
        mem_rdata = 16'hDEAD;
        repeat (3) tick();
        rst = 1'b0;
        b = cyc;
        for (int k = 0; k < N; k++) begin
            pin(b, k, S_BUSY, 16'd0, "lit_rst_busy");
            pin(b, k, S_MEM_ADDR, 16'd0, "lit_rst_addr");
            pin(b, k, S_IF_RD, 16'd0, "lit_rst_if_rdata");
        end
        wait_to(b + 2);

        // Single fetch
        b = cyc;
        if_req = 1'b1; if_addr = 16'h0010;
        pin(b + 1, 0, S_MEM_RE, 16'd1, "lit_fetch_re");
        pin(b + 1, 0, S_MEM_ADDR, 16'h0010, "lit_fetch_addr");
        pin(b + 3, 0, S_IF_STALL, 16'd1, "lit_fetch_stall");
        pin(b + 3, 0, S_IF_ACK, 16'd0, "lit_fetch_not_early");
        pin(b + 4, 0, S_IF_ACK, 16'd1, "lit_fetch_ack");
        pin(b + 4, 0, S_IF_RD, 16'hA5A5, "lit_fetch_rdata");
        pin(b + 4, 0, S_IF_STALL, 16'd0, "lit_fetch_stall_rel");
        wait_to(b + 3); mem_rdata = 16'hA5A5;
        wait_to(b + 4); mem_rdata = 16'hDEAD;
        wait_to(b + 5); if_req = 1'b0;
        pin(b + 8, 0, S_IF_RD, 16'hA5A5, "lit_fetch_hold");
        wait_to(b + 20);

        // Data read, then a store that must leave dm_rdata unchanged
        b = cyc;
        dm_re = 1'b1; dm_addr = 16'h0050;
        pin(b + 4, 0, S_DM_ACK, 16'd1, "lit_load_ack");
        pin(b + 4, 0, S_DM_RD, 16'h5A5A, "lit_load_rdata");
        wait_to(b + 3); mem_rdata = 16'h5A5A;
        wait_to(b + 4); mem_rdata = 16'hDEAD;
        wait_to(b + 5); dm_re = 1'b0;
        wait_to(b + 20);
        b = cyc;
        dm_we = 1'b1; dm_re = 1'b1; dm_addr = 16'h0040; dm_wdata = 16'h1234;
        pin(b + 1, 0, S_MEM_WE, 16'd1, "lit_store_we");
        pin(b + 1, 0, S_MEM_RE, 16'd0, "lit_store_no_re");
        pin(b + 1, 0, S_MEM_WD, 16'h1234, "lit_store_wdata");
        pin(b + 1, 0, S_MEM_ADDR, 16'h0040, "lit_store_addr");
        pin(b + 3, 0, S_DM_STALL, 16'd1, "lit_store_stall");
        pin(b + 4, 0, S_DM_ACK, 16'd1, "lit_store_ack");
        pin(b + 4, 0, S_DM_RD, 16'h5A5A, "lit_store_keeps_rdata");
        wait_to(b + 5); dm_we = 1'b0; dm_re = 1'b0; dm_wdata = 16'd0;
        wait_to(b + 20);

        // Ties right after a reset, then a second tie
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b = cyc;
        pin(b, 0, S_BUSY, 16'd0, "lit_rst2_busy");
        pin(b, 0, S_DM_RD, 16'd0, "lit_rst2_dm_rdata");
        pin(b, 0, S_MEM_ADDR, 16'd0, "lit_rst2_addr");
`ifdef MEM_ARB_RR_EN
        conflict(1'b1);
        wait_to(cyc + 2);
        conflict(1'b1);
`else
        conflict(1'b0);
        wait_to(cyc + 2);
        conflict(1'b0);
`endif
        wait_to(cyc + 20);

        // Reset during WAIT abandons the fetch; a fresh request follows
        b = cyc;
        if_req = 1'b1; if_addr = 16'h0070;
        wait_to(b + 2); rst = 1'b1;
        wait_to(b + 3); rst = 1'b0;
        pin(b + 3, 0, S_BUSY, 16'd0, "lit_rstw_busy");
        pin(b + 3, 0, S_MEM_RE, 16'd0, "lit_rstw_no_re");
        pin(b + 3, 0, S_IF_RD, 16'd0, "lit_rstw_rdata");
        pin(b + 4, 0, S_IF_ACK, 16'd0, "lit_rstw_no_ack");
        pin(b + 7, 0, S_IF_ACK, 16'd1, "lit_rstw_new_ack");
        pin(b + 7, 0, S_IF_RD, 16'h7777, "lit_rstw_new_rdata");
        wait_to(b + 6); mem_rdata = 16'h7777;
        wait_to(b + 7); mem_rdata = 16'hDEAD;
        wait_to(b + 8); if_req = 1'b0;
        wait_to(b + 25);

        // One-cycle request: latency extremes
        b = cyc;
        if_req = 1'b1; if_addr = 16'h0123;
        pin(b + 2, 1, S_IF_ACK, 16'd0, "lit_lat1_not_early");
        pin(b + 3, 1, S_IF_ACK, 16'd1, "lit_lat1_ack");
        pin(b + 4, 0, S_IF_ACK, 16'd1, "lit_lat2_ack");
        pin(b + 16, 2, S_IF_ACK, 16'd0, "lit_lat15_not_early");
        pin(b + 17, 2, S_IF_ACK, 16'd1, "lit_lat15_ack");
        tick();
        if_req = 1'b0;
        wait_to(b + 22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
